// File: rtl/axi_regfile_pkg.sv
// Shared constants and types for the AXI4-Lite control/status register file.
package axi_regfile_pkg;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;
  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HOLD,
    WR_RESP
  } wr_state_t;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axi_lite_wr_capture.sv
// AXI4-Lite write-channel front end: independent AW/W hold registers and the
// IDLE/HOLD/RESP handshake FSM. Emits a one-cycle commit with the merged request.
module axi_lite_wr_capture
  import axi_regfile_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic              bvalid,
  input  logic              bready,
  output logic              commit,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [31:0]       commit_data,
  output logic [3:0]        commit_strb
);

  wr_state_t         state, state_next;
  logic              ready_en;
  logic              aw_held, w_held;
  logic              aw_fire, w_fire;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        strb_q;

  // A channel already parked in a hold register keeps its ready low until the
  // partner arrives; ready_en keeps everything quiet for the first cycle after reset.
  always_comb begin
    state_next = state;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (state)
      WR_IDLE: begin
        awready = ready_en;
        wready  = ready_en;
      end
      WR_HOLD: begin
        awready = !aw_held;
        wready  = !w_held;
      end
      WR_RESP: bvalid = 1'b1;
      default: ;
    endcase
    aw_fire = awvalid && awready;
    w_fire  = wvalid && wready;
    commit  = (state != WR_RESP) && (aw_fire || aw_held) && (w_fire || w_held);
    case (state)
      WR_IDLE, WR_HOLD: begin
        if (commit)                 state_next = WR_RESP;
        else if (aw_fire || w_fire) state_next = WR_HOLD;
      end
      WR_RESP: if (bready) state_next = WR_IDLE;
      default: state_next = WR_IDLE;
    endcase
  end

  assign commit_addr = aw_held ? addr_q : awaddr;
  assign commit_data = w_held ? data_q : wdata;
  assign commit_strb = w_held ? strb_q : wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WR_IDLE;
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
    end else begin
      ready_en <= 1'b1;
      state    <= state_next;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_fire) begin
          aw_held <= 1'b1;
          addr_q  <= awaddr;
        end
        if (w_fire) begin
          w_held <= 1'b1;
          data_q <= wdata;
          strb_q <= wstrb;
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite control/status register file: RW control regs with pulse bits,
// status regs with sticky W1C bits, a read-only version word, and access strobes.
module axi_lite_regfile
  import axi_regfile_pkg::*;
#(
  parameter int                      N_CTRL      = 4,
  parameter int                      N_STATUS    = 4,
  parameter int                      ADDR_W      = 12,
  parameter logic [32*N_CTRL-1:0]    CTRL_RESET  = '0,
  parameter logic [32*N_CTRL-1:0]    PULSE_MASK  = '0,
  parameter logic [32*N_STATUS-1:0]  STICKY_MASK = '0,
  parameter logic [31:0]             VERSION     = 32'h0002_0000
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_W-1:0]       s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_W-1:0]       s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [32*N_CTRL-1:0]    ctrl_regs,
  output logic [N_CTRL-1:0]       ctrl_wr_pulse,
  input  logic [32*N_STATUS-1:0]  status_regs,
  output logic [N_STATUS-1:0]     status_rd_pulse
);

  localparam int IDX_W   = ADDR_W - 2;
  localparam int VER_IDX = N_CTRL + N_STATUS;

  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [31:0]       commit_data;
  logic [3:0]        commit_strb;
  logic [31:0]       wr_mask;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              unused_addr_bits;

  logic [32*N_CTRL-1:0]   ctrl_q, ctrl_next;
  logic [N_CTRL-1:0]      wr_pulse_next;
  logic [32*N_STATUS-1:0] sticky_q, sticky_next, sticky_clr, status_view;

  logic              ar_en, ar_fire;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic [N_STATUS-1:0] rd_pulse_next;

  axi_lite_wr_capture #(.ADDR_W(ADDR_W)) u_wr_capture (
    .clk         (s_axi_aclk),
    .reset       (s_axi_areset),
    .awaddr      (s_axi_awaddr),
    .awvalid     (s_axi_awvalid),
    .awready     (s_axi_awready),
    .wdata       (s_axi_wdata),
    .wstrb       (s_axi_wstrb),
    .wvalid      (s_axi_wvalid),
    .wready      (s_axi_wready),
    .bvalid      (s_axi_bvalid),
    .bready      (s_axi_bready),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  assign wr_idx           = commit_addr[ADDR_W-1:2];
  assign rd_idx           = s_axi_araddr[ADDR_W-1:2];
  assign wr_mask          = strb_mask(commit_strb);
  assign unused_addr_bits = ^{commit_addr[1:0], s_axi_araddr[1:0]};
  assign ctrl_regs        = ctrl_q;

  // Pulse bits decay every cycle; a write in the same cycle overrides the decay.
  always_comb begin
    ctrl_next     = ctrl_q & ~PULSE_MASK;
    wr_pulse_next = '0;
    for (int i = 0; i < N_CTRL; i++) begin
      if (commit && wr_idx == IDX_W'(i)) begin
        ctrl_next[32*i +: 32] = (ctrl_next[32*i +: 32] & ~wr_mask) | (commit_data & wr_mask);
        wr_pulse_next[i]      = 1'b1;
      end
    end
  end

  // Set dominates clear so an event coinciding with the W1C is never lost.
  always_comb begin
    sticky_clr = '0;
    for (int j = 0; j < N_STATUS; j++) begin
      if (commit && wr_idx == IDX_W'(N_CTRL + j))
        sticky_clr[32*j +: 32] = commit_data & wr_mask;
    end
    sticky_next = ((sticky_q & ~sticky_clr) | status_regs) & STICKY_MASK;
    status_view = (sticky_q & STICKY_MASK) | (status_regs & ~STICKY_MASK);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      ctrl_q        <= CTRL_RESET;
      ctrl_wr_pulse <= '0;
      sticky_q      <= '0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      ctrl_q        <= ctrl_next;
      ctrl_wr_pulse <= wr_pulse_next;
      sticky_q      <= sticky_next;
      if (commit)
        s_axi_bresp <= (wr_idx < IDX_W'(VER_IDX)) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    rd_data       = UNMAPPED_RDATA;
    rd_resp       = RESP_SLVERR;
    rd_pulse_next = '0;
    for (int i = 0; i < N_CTRL; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = ctrl_q[32*i +: 32];
        rd_resp = RESP_OKAY;
      end
    end
    for (int j = 0; j < N_STATUS; j++) begin
      if (rd_idx == IDX_W'(N_CTRL + j)) begin
        rd_data          = status_view[32*j +: 32];
        rd_resp          = RESP_OKAY;
        rd_pulse_next[j] = 1'b1;
      end
    end
    if (rd_idx == IDX_W'(VER_IDX)) begin
      rd_data = VERSION;
      rd_resp = RESP_OKAY;
    end
  end

  assign s_axi_arready = ar_en && !s_axi_rvalid;
  assign ar_fire       = s_axi_arvalid && s_axi_arready;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      ar_en           <= 1'b0;
      s_axi_rvalid    <= 1'b0;
      s_axi_rdata     <= '0;
      s_axi_rresp     <= RESP_OKAY;
      status_rd_pulse <= '0;
    end else begin
      ar_en           <= 1'b1;
      status_rd_pulse <= '0;
      if (ar_fire) begin
        s_axi_rvalid    <= 1'b1;
        s_axi_rdata     <= rd_data;
        s_axi_rresp     <= rd_resp;
        status_rd_pulse <= rd_pulse_next;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: expected B/R responses are queued at issue
// time and popped by a negedge monitor at each handshake.
module tb_axi_lite_regfile;
  import axi_regfile_pkg::*;

  localparam int ADDR_W = 12;
  localparam logic [127:0] CTRL_RST = {32'h0, 32'h0, 32'hA5A5_0001, 32'h0};

  logic          clk = 1'b0;
  logic          reset;
  logic [11:0]   awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [127:0]  ctrl_regs, status_regs;
  logic [3:0]    ctrl_wr_pulse, status_rd_pulse;

  int checks = 0;
  int errors = 0;
  logic [1:0]  exp_b[$];
  logic [31:0] exp_rdata[$];
  logic [1:0]  exp_rresp[$];

  axi_lite_regfile #(
    .N_CTRL(4), .N_STATUS(4), .ADDR_W(ADDR_W),
    .CTRL_RESET(CTRL_RST), .PULSE_MASK(128'h1), .STICKY_MASK(128'h8),
    .VERSION(32'h0002_0000)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse),
    .status_regs(status_regs), .status_rd_pulse(status_rd_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every B/R handshake is compared against the head of its queue.
  always @(negedge clk) begin
    if (!reset && bvalid && bready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_b: bresp %0h with empty queue", bresp);
      end else begin
        checkOutput("bresp", bresp, exp_b.pop_front());
      end
    end
    if (!reset && rvalid && rready) begin
      if (exp_rdata.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_r: rdata %0h with empty queue", rdata);
      end else begin
        checkOutput("rdata", rdata, exp_rdata.pop_front());
        checkOutput("rresp", rresp, exp_rresp.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issues AW/W with independent start delays; returns one step after the commit edge.
  task automatic writeReg(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input logic [1:0] resp);
    int cyc = 0;
    logic aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    exp_b.push_back(resp);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = (aw_delay == 0);
    wvalid  = (w_delay == 0);
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      cyc++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
      if (!aw_done && cyc >= aw_delay) awvalid = 1'b1;
      if (!w_done && cyc >= w_delay)   wvalid = 1'b1;
      if (w_done && !aw_done) checkOutput("hold_ready_w", {awready, wready}, 2'b10);
      if (aw_done && !w_done) checkOutput("hold_ready_aw", {awready, wready}, 2'b01);
      if (cyc > 40) begin
        checks++; errors++;
        $display("[TB] FAIL write_timeout: addr %0h not accepted", addr);
        awvalid = 1'b0; wvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic waitB();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bvalid && bready) begin tick(); return; end
    end
    checks++; errors++;
    $display("[TB] FAIL b_timeout: bvalid %0b required 1", bvalid);
  endtask

  // Issues AR; returns one step after the AR handshake edge.
  task automatic readReg(input logic [11:0] addr, input logic [31:0] data, input logic [1:0] resp);
    logic hs;
    exp_rdata.push_back(data);
    exp_rresp.push_back(resp);
    araddr = addr; arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      hs = arvalid && arready;
      tick();
      if (hs) begin arvalid = 1'b0; return; end
    end
    arvalid = 1'b0;
    checks++; errors++;
    $display("[TB] FAIL ar_timeout: addr %0h not accepted", addr);
  endtask

  task automatic waitR();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rvalid && rready) begin tick(); return; end
    end
    checks++; errors++;
    $display("[TB] FAIL r_timeout: rvalid %0b required 1", rvalid);
  endtask

  task automatic doWrite(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [1:0] resp);
    writeReg(addr, data, strb, 0, 0, resp);
    waitB();
  endtask

  task automatic doRead(input logic [11:0] addr, input logic [31:0] data, input logic [1:0] resp);
    readReg(addr, data, resp);
    waitR();
  endtask

  task automatic applyStimulus();
    // Reset state and release
    reset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1; status_regs = '0;
    repeat (3) tick();
    checkOutput("reset_handshake", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    checkOutput("reset_resp", {bresp, rresp}, 4'b0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_ctrl", ctrl_regs, CTRL_RST);
    checkOutput("reset_pulses", {ctrl_wr_pulse, status_rd_pulse}, 8'h0);
    reset = 1'b0;
    tick();
    checkOutput("ready_after_reset", {awready, wready, arready}, 3'b111);

    // W first, AW three cycles later, low two byte lanes
    writeReg(12'h004, 32'h1234_5678, 4'b0011, 3, 0, RESP_OKAY);
    checkOutput("ctrl1_lanes", ctrl_regs[32 +: 32], 32'hA5A5_5678);
    checkOutput("wr_pulse_1", ctrl_wr_pulse, 4'b0010);
    waitB();
    checkOutput("wr_pulse_1_end", ctrl_wr_pulse, 4'b0000);

    // Self-clearing pulse bit in reg0
    writeReg(12'h000, 32'h1, 4'b1111, 0, 0, RESP_OKAY);
    checkOutput("pulse_high", ctrl_regs[31:0], 32'h1);
    checkOutput("wr_pulse_0", ctrl_wr_pulse, 4'b0001);
    waitB();
    checkOutput("pulse_low", ctrl_regs[31:0], 32'h0);
    doRead(12'h000, 32'h0, RESP_OKAY);

    // AW first, then W; then a single upper-lane update
    writeReg(12'h008, 32'h1122_3344, 4'b1111, 0, 2, RESP_OKAY);
    waitB();
    doWrite(12'h008, 32'hAABB_CCDD, 4'b0100, RESP_OKAY);
    doRead(12'h008, 32'h11BB_3344, RESP_OKAY);

    // Sticky status bit 3 of status0, W1C, and set-wins-over-clear
    status_regs = {32'h0, 32'h0, 32'hCAFE_0011, 32'h0};
    status_regs[3] = 1'b1;
    tick();
    status_regs[3] = 1'b0;
    doRead(12'h010, 32'h8, RESP_OKAY);
    doWrite(12'h010, 32'h8, 4'b1111, RESP_OKAY);
    doRead(12'h010, 32'h0, RESP_OKAY);
    status_regs[3] = 1'b1;
    writeReg(12'h010, 32'h8, 4'b1111, 0, 0, RESP_OKAY);
    status_regs[3] = 1'b0;
    waitB();
    doRead(12'h010, 32'h8, RESP_OKAY);
    doWrite(12'h010, 32'h8, 4'b1111, RESP_OKAY);
    doRead(12'h010, 32'h0, RESP_OKAY);

    // Live status, version word, unmapped reads
    readReg(12'h014, 32'hCAFE_0011, RESP_OKAY);
    checkOutput("rd_pulse_1", status_rd_pulse, 4'b0010);
    waitR();
    checkOutput("rd_pulse_1_end", status_rd_pulse, 4'b0000);
    doRead(12'h020, 32'h0002_0000, RESP_OKAY);
    doRead(12'h024, UNMAPPED_RDATA, RESP_SLVERR);
    doRead(12'h100, UNMAPPED_RDATA, RESP_SLVERR);

    // Writes to version and unmapped space are rejected with no side effects
    writeReg(12'h020, 32'hFFFF_FFFF, 4'b1111, 0, 1, RESP_SLVERR);
    checkOutput("ver_wr_pulse", ctrl_wr_pulse, 4'b0000);
    waitB();
    writeReg(12'h100, 32'hFFFF_FFFF, 4'b1111, 2, 0, RESP_SLVERR);
    waitB();
    checkOutput("ctrl_after_slverr", ctrl_regs, {32'h0, 32'h11BB_3344, 32'hA5A5_5678, 32'h0});
    doRead(12'h020, 32'h0002_0000, RESP_OKAY);

    // Read and write of reg2 on the same edge: read sees the old value
    fork
      begin writeReg(12'h008, 32'h5555_5555, 4'b1111, 0, 0, RESP_OKAY); waitB(); end
      begin readReg(12'h008, 32'h11BB_3344, RESP_OKAY); waitR(); end
    join
    doRead(12'h008, 32'h5555_5555, RESP_OKAY);

    // B stalled for 5 cycles while a second write is offered
    bready = 1'b0;
    writeReg(12'h00C, 32'h0BAD_F00D, 4'b1111, 0, 0, RESP_OKAY);
    awaddr = 12'h00C; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      checkOutput("b_stall_valid", {bvalid, bresp}, {1'b1, RESP_OKAY});
      checkOutput("b_stall_ready", {awready, wready}, 2'b00);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("b_stall_ctrl3", ctrl_regs[96 +: 32], 32'h0BAD_F00D);
    bready = 1'b1;
    waitB();

    // R stalled for 5 cycles while a status read is offered
    rready = 1'b0;
    readReg(12'h00C, 32'h0BAD_F00D, RESP_OKAY);
    araddr = 12'h010; arvalid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      checkOutput("r_stall_valid", {rvalid, rdata}, {1'b1, 32'h0BAD_F00D});
      checkOutput("r_stall_ready", {arready, status_rd_pulse}, 5'b0);
      tick();
    end
    arvalid = 1'b0;
    rready = 1'b1;
    waitR();
    repeat (2) tick();
    checkOutput("queues_drained", {exp_b.size() == 0, exp_rdata.size() == 0}, 2'b11);
  endtask

  initial begin
    $display("[TB] starting axi_lite_regfile bench");
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
